// File: rtl/prog_ctr_seq.sv
// prog_ctr_seq: program-counter sequencer for the 3BC fetch path.
// Holds the current instruction address and selects the next PC each cycle
// (increment, taken relative branch, taken absolute branch), and tracks the
// program run state IDLE -> RUN -> DONE -> IDLE.
// Optional feature macro: PC_BRANCH_COUNT_EN enables the saturating
// taken-branch counter on branch_count; without it branch_count is tied to 0.
module prog_ctr_seq #(
   parameter int PC_W = 10
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [PC_W-1:0] start_addr,
   input  logic            stall,
   input  logic            halt,
   input  logic            branch_abs_en,
   input  logic            branch_rel_en,
   input  logic            taken,
   input  logic [9:0]      target,
   output logic [PC_W-1:0] prog_ctr,
   output logic            running,
   output logic            done,
   output logic [15:0]     branch_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t          state_reg, state_next;
   logic [PC_W-1:0] pc_reg, pc_next;
   logic            branch_fire;
   logic            start_accept;

   // Target interpretations: unsigned address for absolute, two's-complement
   // offset for relative (sign-extended so the add wraps modulo 2^PC_W).
   logic [PC_W-1:0] abs_tgt;
   logic [PC_W-1:0] rel_off;
   assign abs_tgt = PC_W'(target);
   assign rel_off = PC_W'($signed(target));

   // State and PC registers; reset wins over every other input.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         pc_reg    <= '0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
      end
   end

   // Next-state / next-PC selection with stall > halt > abs > rel > increment.
   always_comb begin
      state_next   = state_reg;
      pc_next      = pc_reg;
      branch_fire  = 1'b0;
      start_accept = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               pc_next      = start_addr;
               state_next   = ST_RUN;
               start_accept = 1'b1;
            end
         end
         ST_RUN: begin
            if (!stall) begin
               if (halt) begin
                  state_next = ST_DONE;
               end else if (branch_abs_en && taken) begin
                  pc_next     = abs_tgt;
                  branch_fire = 1'b1;
               end else if (branch_rel_en && taken) begin
                  pc_next     = pc_reg + rel_off;
                  branch_fire = 1'b1;
               end else begin
                  pc_next = pc_reg + PC_W'(1);
               end
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign prog_ctr = pc_reg;
   assign running  = (state_reg == ST_RUN);
   assign done     = (state_reg == ST_DONE);

`ifdef PC_BRANCH_COUNT_EN
   logic [15:0] bc_reg;

   // Saturating count of taken branches, cleared when a new program starts.
   always_ff @(posedge clk) begin
      if (reset) begin
         bc_reg <= '0;
      end else if (start_accept) begin
         bc_reg <= '0;
      end else if (branch_fire && (bc_reg != 16'hFFFF)) begin
         bc_reg <= bc_reg + 16'd1;
      end
   end

   assign branch_count = bc_reg;
`else
   logic unused_bc_sigs;
   assign unused_bc_sigs = branch_fire ^ start_accept;
   assign branch_count   = 16'd0;
`endif

endmodule
